// File: rtl/riscv_structures.sv
// Shared RV32 definitions used by the execute-stage units.
// Holds the M-extension opcode and sequencer encodings plus the divide special-case constants.
package riscv_structures;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  // INT_MIN maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
    return (is_signed && value[31]) ? (32'd0 - value) : value;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle over a shared 64-bit accumulator.
// Sits between the register file read ports and writeback, with valid/ready on both sides.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  import riscv_structures::*;

  muldiv_state_e     state;
  muldiv_op_e        op;
  muldiv_op_e        op_in;
  logic [4:0]        count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   b_mag;
  logic              neg_q;
  logic              neg_r;

  logic              a_sgn;
  logic              b_sgn;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_result;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_result;

  assign in_ready = (state == IDLE);
  assign op_in    = muldiv_op_e'(funct3);

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (op_in)
      MUL, MULH, DIV, REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      MULHSU:  a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign div_zero = funct3[2] && (rs2_val == '0);
  assign div_ovf  = ((op_in == DIV) || (op_in == REM)) &&
                    (rs1_val == INT_MIN) && (rs2_val == DIV_BY_ZERO_Q);

  always_comb begin
    special_result = funct3[1] ? '0 : INT_MIN;
    if (div_zero) special_result = funct3[1] ? rs1_val : DIV_BY_ZERO_Q;
  end

  // Multiply: multiplier sits in the low half and shifts out while the product fills from the top.
  // Divide: dividend shifts out of the low half into the partial remainder; quotient bits shift in.
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign rem_shift = acc[2*XLEN-1:XLEN-1];
  assign div_diff  = rem_shift - {1'b0, b_mag};

  always_comb begin
    if (!op[2])
      step_acc = {mul_sum, acc[XLEN-1:1]};
    else if (div_diff[XLEN])
      step_acc = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      step_acc = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  assign prod_fix = neg_q ? ('0 - step_acc) : step_acc;
  assign quot_fix = neg_q ? ('0 - step_acc[XLEN-1:0]) : step_acc[XLEN-1:0];
  assign rem_fix  = neg_r ? ('0 - step_acc[2*XLEN-1:XLEN]) : step_acc[2*XLEN-1:XLEN];

  always_comb begin
    final_result = rem_fix;
    unique case (op)
      MUL:                 final_result = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: final_result = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:           final_result = quot_fix;
      default:             final_result = rem_fix;
    endcase
  end

  // Special cases park in DONE with valid held low for one cycle so they surface one edge after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= MUL;
      count     <= '0;
      acc       <= '0;
      b_mag     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
    end else if (kill) begin
      state     <= IDLE;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op     <= op_in;
            rd_out <= rd_in;
            b_mag  <= magnitude(rs2_val, b_sgn);
            neg_q  <= (a_sgn & rs1_val[XLEN-1]) ^ (b_sgn & rs2_val[XLEN-1]);
            neg_r  <= a_sgn & rs1_val[XLEN-1];
            if (div_zero || div_ovf) begin
              state  <= DONE;
              result <= special_result;
            end else begin
              state <= CALC;
              count <= 5'd31;
              acc   <= {{XLEN{1'b0}}, magnitude(rs1_val, a_sgn)};
            end
          end
        end
        CALC: begin
          acc <= step_acc;
          if (count == 5'd0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= final_result;
          end else begin
            count <= count - 5'd1;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M corner cases, random operations checked
// against an arithmetic model, plus back-pressure, kill and mid-operation reset.
module tb_muldiv_unit;
  import riscv_structures::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        kill = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_val = 32'd0;
  logic [31:0] rs2_val = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rd_out(rd_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference arithmetic built from the simulator's own 64-bit operators.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'b000: begin p = 64'(sa * sb); return p[31:0]; end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = 64'(ua * ub); return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'b101: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int budget = 0;
    while (!in_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    funct3   = f;
    rs1_val  = a;
    rs2_val  = b;
    rd_in    = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    funct3   = 3'($urandom);
    rs1_val  = $urandom;
    rs2_val  = $urandom;
    rd_in    = 5'($urandom);
  endtask

  task automatic collectResult(input string tag);
    exp_t e;
    int lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (sb_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      checkOutput({tag, "_lat"}, 32'(lat), 32'(e.lat));
      checkOutput({tag, "_res"}, result, e.res);
      checkOutput({tag, "_rd"}, {27'd0, rd_out}, {27'd0, e.rd});
    end
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_rel_ready"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat);
    exp_t e;
    e.res = res;
    e.rd  = rd;
    e.lat = lat;
    sb_q.push_back(e);
    applyStimulus(f, a, b, rd);
    collectResult(tag);
    releaseResult(tag);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int          rlat;
    int          seen;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_rd", {27'd0, rd_out}, 32'd0);
    checkOutput("reset_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    runOp("mul_neg",  3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 32);
    runOp("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 32);
    runOp("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, 32);
    runOp("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, 32);
    runOp("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 1);
    runOp("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         1);
    runOp("divu_z",   3'b101, 32'd123,        32'd0,         5'd11, 32'hFFFF_FFFF, 1);
    runOp("remu_z",   3'b111, 32'd123,        32'd0,         5'd12, 32'd123,       1);
    runOp("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFF, 32);
    runOp("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2,         5'd0,  32'hFFFF_FFFD, 32);

    for (int i = 0; i < 12; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (i == 4) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      rlat = (rf[2] && (rb == 32'd0 || (!rf[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))) ? 1 : 32;
      runOp($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, 5'(i + 1), model(rf, ra, rb), rlat);
    end

    begin
      exp_t e;
      e.res = 32'd14; e.rd = 5'd20; e.lat = 32;
      sb_q.push_back(e);
      applyStimulus(3'b101, 32'd100, 32'd7, 5'd20);
      collectResult("hold");
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        checkOutput($sformatf("hold_res%0d", i), result, 32'd14);
        checkOutput($sformatf("hold_ready%0d", i), {31'd0, in_ready}, 32'd0);
      end
      releaseResult("hold");
    end

    applyStimulus(3'b000, 32'h1234_5678, 32'h09AB_CDEF, 5'd21);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checkOutput("kill_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("kill_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("kill_no_valid", 32'(seen), 32'd0);
    runOp("after_kill", 3'b000, 32'd3, 32'd4, 5'd22, 32'd12, 32);

    applyStimulus(3'b101, 32'd123, 32'd0, 5'd23);
    seen = 0;
    while (!out_valid && seen < 10) begin
      @(posedge clk); #1;
      seen++;
    end
    checkOutput("kdone_valid", {31'd0, out_valid}, 32'd1);
    kill = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    out_ready = 1'b0;
    checkOutput("kdone_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("kdone_ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(3'b001, 32'hDEAD_BEEF, 32'h1357_9BDF, 5'd25);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    kill = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    kill = 1'b0;
    checkOutput("mreset_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mreset_result", result, 32'd0);
    checkOutput("mreset_rd", {27'd0, rd_out}, 32'd0);
    checkOutput("mreset_ready", {31'd0, in_ready}, 32'd1);
    runOp("after_reset", 3'b111, 32'd100, 32'd7, 5'd26, 32'd2, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
